// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host protocol: wire command bytes, request
// encoding, initiator FSM states and the baud divisor helper.
package uart_host_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RST_A = 8'hFE;
    localparam logic [7:0] CMD_RST_D = 8'hFF;

    typedef enum logic [1:0] {
        ReqRead  = 2'd0,
        ReqWrite = 2'd1,
        ReqRstA  = 2'd2,
        ReqRstD  = 2'd3
    } req_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StResp
    } state_e;

    // Clocks per bit minus one; clk_freq is in MHz.
    function automatic logic [15:0] cfg_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
        logic [63:0] q;
        q = (64'(clk_freq) * 64'd1000000) / 64'(baud_rate) - 64'd1;
        return q[15:0];
    endfunction

    function automatic logic [7:0] cmd_byte(input req_cmd_e c);
        logic [7:0] b;
        b = CMD_READ;
        unique case (c)
            ReqRead:  b = CMD_READ;
            ReqWrite: b = CMD_WRITE;
            ReqRstA:  b = CMD_RST_A;
            ReqRstD:  b = CMD_RST_D;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_core.sv
// 8N1/8N2 UART: byte-wide TX with valid/ready, RX with a one-cycle valid pulse.
module uart_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_div,
    input  logic        cfg_nstop,
    input  logic        cfg_txen,
    input  logic        cfg_rxen,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        txd,
    input  logic        rxd
);
    logic [10:0] tx_shift;
    logic [3:0]  tx_bits;
    logic [15:0] tx_cnt;
    logic        rx_s1;
    logic        rx_s2;
    logic [3:0]  rx_phase;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_sr;

    // Idle shift register is all ones, so the line rests high.
    assign txd      = tx_shift[0];
    assign tx_ready = (tx_bits == 4'd0) & cfg_txen;

    // Transmitter: load start/data/stop frame, shift one bit every cfg_div+1 clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_bits  <= 4'd0;
            tx_cnt   <= 16'd0;
        end else if (tx_valid && tx_ready) begin
            tx_shift <= {2'b11, tx_data, 1'b0};
            tx_bits  <= cfg_nstop ? 4'd11 : 4'd10;
            tx_cnt   <= cfg_div;
        end else if (tx_bits != 4'd0) begin
            if (tx_cnt == 16'd0) begin
                tx_shift <= {1'b1, tx_shift[10:1]};
                tx_bits  <= tx_bits - 4'd1;
                tx_cnt   <= cfg_div;
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    // Receiver: phase 0 idle, 1 start check, 2..9 data bits, 10 stop; samples mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_phase <= 4'd0;
            rx_cnt   <= 16'd0;
            rx_sr    <= 8'd0;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_valid <= 1'b0;
            if (!cfg_rxen) begin
                rx_phase <= 4'd0;
            end else if (rx_phase == 4'd0) begin
                if (!rx_s2) begin
                    rx_phase <= 4'd1;
                    rx_cnt   <= cfg_div >> 1;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= cfg_div;
                if (rx_phase == 4'd1) begin
                    rx_phase <= rx_s2 ? 4'd0 : 4'd2;
                end else if (rx_phase == 4'd10) begin
                    rx_phase <= 4'd0;
                    if (rx_s2) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                    end
                end else begin
                    rx_sr    <= {rx_s2, rx_sr[7:1]};
                    rx_phase <= rx_phase + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_host_master.sv
// UART host protocol initiator: serialises read/write/reset requests and
// collects read responses with an inter-byte timeout.
module uart_host_master
    import uart_host_pkg::*;
#(
    parameter int unsigned ADDR_BYTE   = 2,
    parameter int unsigned DATA_BYTE   = 2,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned CLK_FREQ    = 100,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   uart_txd,
    input  logic                   uart_rxd,
    input  logic                   enable,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_cmd,
    input  logic [8*ADDR_BYTE-1:0] req_addr,
    input  logic [8*DATA_BYTE-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [8*DATA_BYTE-1:0] rsp_rdata,
    output logic                   rsp_timeout,
    output logic                   wr_done,
    output logic                   rx_drop,
    output logic                   busy
);
    localparam int unsigned AW   = 8 * ADDR_BYTE;
    localparam int unsigned DW   = 8 * DATA_BYTE;
    localparam int unsigned MAXB = (ADDR_BYTE > DATA_BYTE) ? ADDR_BYTE : DATA_BYTE;
    localparam int unsigned BW   = $clog2(MAXB + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTE - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   DIV       = cfg_div(CLK_FREQ, BAUD_RATE);

    state_e        state;
    req_cmd_e      cmd_lat;
    logic [AW-1:0] addr_sr;
    logic [DW-1:0] data_sr;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_hs;
    logic          is_rst;

    assign req_ready = (state == StIdle) & enable;
    assign busy      = (state != StIdle);
    assign tx_valid  = (state == StCmd) | (state == StAddr) | (state == StData);
    assign tx_hs     = tx_valid & tx_ready;
    assign is_rst    = (cmd_lat == ReqRstA) | (cmd_lat == ReqRstD);

    // Outgoing byte: command code, else the low byte of the active shift register.
    always_comb begin
        tx_data = cmd_byte(cmd_lat);
        if (state == StAddr) begin
            tx_data = addr_sr[7:0];
        end else if (state == StData) begin
            tx_data = data_sr[7:0];
        end
    end

    uart_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_div  (DIV),
        .cfg_nstop(1'b0),
        .cfg_txen (enable),
        .cfg_rxen (enable),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .txd      (uart_txd),
        .rxd      (uart_rxd)
    );

    // Protocol FSM with registered pulses and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cmd_lat     <= ReqRead;
            addr_sr     <= '0;
            data_sr     <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wr_done     <= 1'b0;
            rx_drop     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            rx_drop   <= rx_valid & (state != StResp);
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        cmd_lat  <= req_cmd_e'(req_cmd);
                        addr_sr  <= req_addr;
                        data_sr  <= req_wdata;
                        byte_cnt <= '0;
                        state    <= StCmd;
                    end
                end
                StCmd: begin
                    if (tx_hs) begin
                        if (is_rst) begin
                            wr_done <= 1'b1;
                            state   <= StIdle;
                        end else begin
                            state <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (tx_hs) begin
                        addr_sr <= addr_sr >> 8;
                        if (byte_cnt == ADDR_LAST) begin
                            byte_cnt <= '0;
                            if (cmd_lat == ReqWrite) begin
                                state <= StData;
                            end else begin
                                rsp_rdata   <= '0;
                                rsp_timeout <= 1'b0;
                                to_cnt      <= '0;
                                state       <= StResp;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end
                end
                StData: begin
                    if (tx_hs) begin
                        data_sr <= data_sr >> 8;
                        if (byte_cnt == DATA_LAST) begin
                            wr_done <= 1'b1;
                            state   <= StIdle;
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end
                end
                StResp: begin
                    // A byte arriving on the expiry cycle wins and restarts the count.
                    if (rx_valid) begin
                        for (int i = 0; i < DATA_BYTE; i++) begin
                            if (byte_cnt == BW'(i)) rsp_rdata[i*8 +: 8] <= rx_data;
                        end
                        to_cnt <= '0;
                        if (byte_cnt == DATA_LAST) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                            state       <= StIdle;
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_master.sv
// Bench for uart_host_master: a remote-host model with RAM decodes the serial
// stream and replies; scoreboard queues hold expected wire bytes and responses.
module tb_uart_host_master;
    localparam int unsigned AB  = 2;
    localparam int unsigned DB  = 2;
    localparam int unsigned TO  = 2000;
    localparam int unsigned BIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;
    logic        enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'd0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic        wr_done;
    logic        rx_drop;
    logic        busy;

    always #5 clk = ~clk;

    uart_host_master #(
        .ADDR_BYTE  (AB),
        .DATA_BYTE  (DB),
        .BAUD_RATE  (125000),
        .CLK_FREQ   (1),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .wr_done    (wr_done),
        .rx_drop    (rx_drop),
        .busy       (busy)
    );

    typedef struct packed {
        logic [15:0] rdata;
        logic        to;
    } rsp_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_bytes[$];
    logic [7:0]  host_q[$];
    logic [7:0]  stray_q[$];
    rsp_t        exp_rsp[$];
    logic [15:0] host_mem[logic [15:0]];
    logic [15:0] ref_mem[logic [15:0]];
    int          rst_gen = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          drop_cnt = 0;
    int          rsp_cnt = 0;
    int          exp_wr = 0;
    int          exp_rsps = 0;
    int          reply_limit = DB;
    int          host_done_cyc = 0;
    int          rsp_cyc = 0;
    bit          host_rst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic get_word(input int n, input int g, output logic [15:0] w, output bit ok);
        w  = 16'h0;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            while (host_q.size() == 0 && g == rst_gen && budget < 400) begin
                @(negedge clk);
                budget++;
            end
            if (host_q.size() == 0 || g != rst_gen) begin
                ok = 1'b0;
                return;
            end
            w[i*8 +: 8] = host_q.pop_front();
        end
    endtask

    always @(negedge rst_n) rst_gen++;

    // Serial decoder on uart_txd; bytes cut short by reset are discarded.
    initial begin : tx_decoder
        logic [7:0] b;
        int         g;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_txd === 1'b0) begin
                g  = rst_gen;
                ok = 1'b1;
                repeat (BIT / 2) @(negedge clk);
                if (uart_txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (BIT) @(negedge clk);
                if (uart_txd !== 1'b1) ok = 1'b0;
                if (ok && g == rst_gen && rst_n === 1'b1) begin
                    tx_bytes.push_back(b);
                    host_q.push_back(b);
                end
            end
        end
    end

    // Remote host: parses commands, keeps a RAM, replies to reads.
    initial begin : host
        logic [7:0]  c;
        logic [15:0] a;
        logic [15:0] d;
        bit          ok;
        int          g;
        forever begin
            @(negedge clk);
            if (stray_q.size() > 0) begin
                send_byte(stray_q.pop_front());
            end else if (host_q.size() > 0) begin
                c = host_q.pop_front();
                g = rst_gen;
                case (c)
                    8'h01: begin
                        get_word(AB, g, a, ok);
                        if (ok) begin
                            d = host_mem.exists(a) ? host_mem[a] : 16'h0;
                            for (int i = 0; i < reply_limit; i++) send_byte(d[i*8 +: 8]);
                            host_done_cyc = cyc;
                            reply_limit = DB;
                        end
                    end
                    8'h02: begin
                        get_word(AB, g, a, ok);
                        if (ok) get_word(DB, g, d, ok);
                        if (ok) host_mem[a] = d;
                    end
                    8'hFE: host_rst = 1'b1;
                    8'hFF: host_rst = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Wire-byte scoreboard.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            while (tx_bytes.size() > 0) begin
                b = tx_bytes.pop_front();
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %0h expected none", b);
                end else begin
                    check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    // Pulse counters and response scoreboard.
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_done === 1'b1) wr_cnt++;
            if (rx_drop === 1'b1) drop_cnt++;
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got %0h expected none", rsp_rdata);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] wd);
        int budget = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL req_ready_wait: got 0 expected 1");
            return;
        end
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] wd);
        exp_tx.push_back(8'h02);
        exp_tx.push_back(a[7:0]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(wd[7:0]);
        exp_tx.push_back(wd[15:8]);
        ref_mem[a] = wd;
        exp_wr++;
        issue(2'd1, a, wd);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] ed, input logic eto);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(a[7:0]);
        exp_tx.push_back(a[15:8]);
        exp_rsp.push_back('{rdata: ed, to: eto});
        exp_rsps++;
        issue(2'd0, a, 16'h0);
    endtask

    task automatic do_rst(input bit assert_rst);
        exp_tx.push_back(assert_rst ? 8'hFE : 8'hFF);
        exp_wr++;
        issue(assert_rst ? 2'd2 : 2'd3, 16'h0, 16'h0);
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || exp_tx.size() != 0 || exp_rsp.size() != 0) && budget < 6000) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (budget >= 6000) begin
            bad++;
            $display("FAIL %s: got busy/pending expected idle", name);
            exp_tx.delete();
            exp_rsp.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin : main
        int         d0;
        int         r0;
        int         dly;
        int         budget;
        int         k;
        logic [15:0] a;
        logic [15:0] wd;

        host_mem[16'h0010] = 16'hCAFE;
        host_mem[16'h0001] = 16'h12AB;
        ref_mem[16'h0010]  = 16'hCAFE;
        ref_mem[16'h0001]  = 16'h12AB;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_wr_done", 32'(wr_done), 0);
        check("rst_rx_drop", 32'(rx_drop), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_timeout", 32'(rsp_timeout), 0);
        check("rst_txd", 32'(uart_txd), 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(16'h1234, 16'hBEEF);
        wait_done("write_done");
        check("write_wr_done", 32'(wr_cnt), 1);
        check("write_busy", 32'(busy), 0);
        check("write_host_mem", 32'(host_mem[16'h1234]), 32'hBEEF);

        do_read(16'h0010, 16'hCAFE, 1'b0);
        wait_done("read_done");
        check("read_rsp_cnt", 32'(rsp_cnt), 1);

        do_rst(1'b1);
        wait_done("rsta_done");
        check("rsta_host", 32'(host_rst), 1);
        do_rst(1'b0);
        wait_done("rstd_done");
        check("rstd_host", 32'(host_rst), 0);
        check("rst_wr_cnt", 32'(wr_cnt), 3);

        reply_limit = 1;
        do_read(16'h0001, 16'h00AB, 1'b1);
        wait_done("timeout_done");
        dly = rsp_cyc - host_done_cyc;
        check("timeout_latency", 32'((dly >= int'(TO) - 4) && (dly <= int'(TO) + 4)), 1);

        d0 = drop_cnt;
        r0 = rsp_cnt;
        stray_q.push_back(8'h55);
        repeat (120) @(negedge clk);
        check("stray_drop", 32'(drop_cnt - d0), 1);
        check("stray_no_rsp", 32'(rsp_cnt - r0), 0);
        do_read(16'h0010, 16'hCAFE, 1'b0);
        wait_done("after_stray");

        enable = 1'b0;
        @(negedge clk);
        check("en_low_ready", 32'(req_ready), 0);
        enable = 1'b1;

        // Reset while the first address byte is on the wire.
        exp_tx.push_back(8'h01);
        issue(2'd0, 16'h0022, 16'h0);
        budget = 0;
        while (exp_tx.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("midrst_cmd_seen", 32'(exp_tx.size()), 0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rdata", 32'(rsp_rdata), 0);
        check("midrst_timeout", 32'(rsp_timeout), 0);
        check("midrst_txd", 32'(uart_txd), 1);
        check("midrst_wr_done", 32'(wr_done), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        do_read(16'h0010, 16'hCAFE, 1'b0);
        wait_done("after_rst");

        do_write(16'h0003, 16'hA5A5);
        wait_done("loop_write");
        do_read(16'h0003, 16'hA5A5, 1'b0);
        wait_done("loop_read");

        for (int i = 0; i < 10; i++) begin
            k  = int'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 3));
            wd = 16'($urandom);
            case (k)
                0: do_read(a, ref_mem.exists(a) ? ref_mem[a] : 16'h0, 1'b0);
                1: do_write(a, wd);
                2: do_rst(1'b1);
                default: do_rst(1'b0);
            endcase
            wait_done("rand_done");
            if (k >= 2) check("rand_host_rst", 32'(host_rst), (k == 2) ? 1 : 0);
        end

        check("final_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("final_rsp_cnt", 32'(rsp_cnt), 32'(exp_rsps));
        check("final_drop_cnt", 32'(drop_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
